// File: rtl/mmio_data_responder.sv
// Data-side memory responder: word RAM with byte/half/word access, a PWM duty
// register page and free-running microsecond/millisecond timers.
module mmio_data_responder #(
  parameter int unsigned WORDS       = 2048,
  parameter int unsigned CLK_FREQ_HZ = 12000000,
  parameter int unsigned PWM_BITS    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write_mem,
  input  logic [2:0]  funct3,
  input  logic [31:0] write_address,
  input  logic [31:0] write_data,
  input  logic [31:0] read_address,
  output logic [31:0] read_data,
  output logic        access_fault,
  output logic        led,
  output logic        red,
  output logic        green,
  output logic        blue
);

  localparam int unsigned AW       = $clog2(WORDS);
  localparam int unsigned TICK_DIV = CLK_FREQ_HZ / 1000000;
  localparam logic [31:0] RAM_BYTES = 32'(4 * WORDS);
  localparam logic [29:0] PWM_WA    = 30'h3FFF_FFFF;
  localparam logic [29:0] MICROS_WA = 30'h3FFF_FFFE;
  localparam logic [29:0] MILLIS_WA = 30'h3FFF_FFFD;

  logic [31:0]         mem [WORDS];
  logic [PWM_BITS-1:0] duty_q [4];   // 0 blue, 1 green, 2 red, 3 led
  logic [PWM_BITS-1:0] cnt_q;
  logic [31:0]         div_q, micros_q, millis_q;
  logic [9:0]          sub_q;
  logic [31:0]         read_q, read_d;
  logic                fault_q, fault_d;
  logic                led_q, red_q, green_q, blue_q;

  logic [31:0] pwm_word;
  assign pwm_word = {8'(duty_q[3]), 8'(duty_q[2]), 8'(duty_q[1]), 8'(duty_q[0])};

  // Read path
  logic [31:0] rd_word, rd_sh;
  logic        rd_map, rd_bad;

  always_comb begin
    rd_word = '0;
    rd_map  = 1'b1;
    if (read_address < RAM_BYTES)              rd_word = mem[read_address[AW+1:2]];
    else if (read_address[31:2] == PWM_WA)     rd_word = pwm_word;
    else if (read_address[31:2] == MICROS_WA)  rd_word = micros_q;
    else if (read_address[31:2] == MILLIS_WA)  rd_word = millis_q;
    else                                       rd_map  = 1'b0;
  end

  assign rd_sh = rd_word >> {read_address[1:0], 3'b000};

  always_comb begin
    read_d = '0;
    rd_bad = 1'b0;
    unique case (funct3)
      3'b000:  read_d = {{24{rd_sh[7]}}, rd_sh[7:0]};
      3'b100:  read_d = {24'h0, rd_sh[7:0]};
      3'b001:  begin read_d = {{16{rd_sh[15]}}, rd_sh[15:0]}; rd_bad = read_address[0]; end
      3'b101:  begin read_d = {16'h0, rd_sh[15:0]};           rd_bad = read_address[0]; end
      3'b010:  begin read_d = rd_word;                        rd_bad = |read_address[1:0]; end
      default: rd_bad = 1'b1;
    endcase
    if (rd_bad || !rd_map) read_d = '0;
  end

  // Write path
  logic        wr_is_ram, wr_is_pwm, wr_map, wr_bad, wr_ok;
  logic [3:0]  be;
  logic [31:0] wdat;

  assign wr_is_ram = write_address < RAM_BYTES;
  assign wr_is_pwm = write_address[31:2] == PWM_WA;
  assign wr_map    = wr_is_ram || wr_is_pwm ||
                     write_address[31:2] == MICROS_WA || write_address[31:2] == MILLIS_WA;

  always_comb begin
    be     = '0;
    wdat   = write_data;
    wr_bad = 1'b0;
    unique case (funct3)
      3'b000:  begin be = 4'b0001 << write_address[1:0]; wdat = {4{write_data[7:0]}}; end
      3'b001:  begin be = 4'b0011 << write_address[1:0]; wdat = {2{write_data[15:0]}};
                     wr_bad = write_address[0]; end
      3'b010:  begin be = 4'b1111; wr_bad = |write_address[1:0]; end
      default: wr_bad = 1'b1;
    endcase
    if (!wr_map) wr_bad = 1'b1;
  end

  assign wr_ok   = write_mem && !wr_bad && !reset;
  assign fault_d = (rd_bad || !rd_map) || (write_mem && wr_bad);

  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < 4; b++) begin
      if (wr_ok && wr_is_ram && be[b]) mem[write_address[AW+1:2]][b*8 +: 8] <= wdat[b*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      read_q   <= '0;
      fault_q  <= 1'b0;
      cnt_q    <= '0;
      div_q    <= '0;
      sub_q    <= '0;
      micros_q <= '0;
      millis_q <= '0;
      led_q    <= 1'b0;
      red_q    <= 1'b0;
      green_q  <= 1'b0;
      blue_q   <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) duty_q[i] <= '0;
    end else begin
      read_q  <= read_d;
      fault_q <= fault_d;
      for (int unsigned i = 0; i < 4; i++) begin
        if (wr_ok && wr_is_pwm && be[i]) duty_q[i] <= PWM_BITS'(wdat[i*8 +: 8]);
      end
      cnt_q   <= cnt_q + 1'b1;
      blue_q  <= cnt_q < duty_q[0];
      green_q <= cnt_q < duty_q[1];
      red_q   <= cnt_q < duty_q[2];
      led_q   <= cnt_q < duty_q[3];
      // micros ticks on divider wrap; millis ticks on every 1000th micro tick
      if (div_q == 32'(TICK_DIV - 1)) begin
        div_q    <= '0;
        micros_q <= micros_q + 32'd1;
        if (sub_q == 10'd999) begin
          sub_q    <= '0;
          millis_q <= millis_q + 32'd1;
        end else begin
          sub_q <= sub_q + 10'd1;
        end
      end else begin
        div_q <= div_q + 32'd1;
      end
    end
  end

  assign read_data    = read_q;
  assign access_fault = fault_q;
  assign led          = led_q;
  assign red          = red_q;
  assign green        = green_q;
  assign blue         = blue_q;

endmodule

// File: tb/tb_mmio_data_responder.sv
// Bench for mmio_data_responder: directed vector table, timer and PWM sequences,
// and randomized traffic against a byte-level reference model.
module tb_mmio_data_responder;

  logic        clk = 1'b0;
  logic        reset, write_mem;
  logic [2:0]  funct3;
  logic [31:0] write_address, write_data, read_address, read_data;
  logic        access_fault, led, red, green, blue;

  mmio_data_responder #(.WORDS(2048), .CLK_FREQ_HZ(4000000), .PWM_BITS(8)) dut (
    .clk(clk), .reset(reset), .write_mem(write_mem), .funct3(funct3),
    .write_address(write_address), .write_data(write_data),
    .read_address(read_address), .read_data(read_data), .access_fault(access_fault),
    .led(led), .red(red), .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  // Clock edges seen out of reset; timers are derived from this.
  int unsigned cyc = 0;
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic we, input logic [2:0] f3,
                       input logic [31:0] wa, input logic [31:0] wd, input logic [31:0] ra);
    reset = rst; write_mem = we; funct3 = f3;
    write_address = wa; write_data = wd; read_address = ra;
  endtask

  // Reference model: byte-addressed RAM image and the four duty bytes.
  logic [7:0] mram [8192];
  logic [7:0] mduty [4];

  function automatic int unsigned msize(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit mmapped(input logic [31:0] a);
    return (a < 32'd8192) || (a >= 32'hFFFF_FFF4);
  endfunction

  function automatic logic [7:0] mbyte(input logic [31:0] a, input int unsigned k);
    logic [31:0] t;
    int unsigned lane;
    lane = a % 4;
    if (a < 32'd8192) return mram[a];
    if (a >= 32'hFFFF_FFFC) return mduty[lane];
    if (a >= 32'hFFFF_FFF8) t = k / 4;
    else                    t = k / 4000;
    return t[8*lane +: 8];
  endfunction

  task automatic apply(input logic rst, input logic we, input logic [2:0] f3,
                       input logic [31:0] wa, input logic [31:0] wd, input logic [31:0] ra,
                       input string tag);
    int unsigned rs, ws;
    logic [31:0] exp_rd, tmp;
    logic        rflt, wflt;
    rs = msize(f3);
    ws = (f3 <= 3'd2) ? rs : 0;
    rflt = (rs == 0) || (ra % rs != 0) || !mmapped(ra);
    wflt = we && ((ws == 0) || (wa % ws != 0) || !mmapped(wa));
    exp_rd = '0;
    if (!rflt) begin
      for (int unsigned b = 0; b < rs; b++) exp_rd[8*b +: 8] = mbyte(ra + b, cyc);
      if (!f3[2] && rs == 1 && exp_rd[7])  exp_rd[31:8]  = '1;
      if (!f3[2] && rs == 2 && exp_rd[15]) exp_rd[31:16] = '1;
    end
    if (rst) exp_rd = '0;
    drive(rst, we, f3, wa, wd, ra);
    step();
    check32({tag, "_rdata"}, read_data, exp_rd);
    check32({tag, "_fault"}, 32'(access_fault), 32'((rflt || wflt) && !rst));
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) mduty[i] = '0;
    end else if (we && !wflt) begin
      tmp = wd;
      for (int unsigned b = 0; b < ws; b++) begin
        if (wa + b < 32'd8192)              mram[wa + b] = tmp[8*b +: 8];
        else if (wa + b >= 32'hFFFF_FFFC)   mduty[(wa + b) % 4] = tmp[8*b +: 8];
      end
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] wa, wd, ra, rd;
    logic        flt;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] wa,
                              input logic [31:0] wd, input logic [31:0] ra,
                              input logic [31:0] rd, input logic flt);
    vec_t v;
    v.we = we; v.f3 = f3; v.wa = wa; v.wd = wd; v.ra = ra; v.rd = rd; v.flt = flt;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    int hi_l, hi_r, hi_g, hi_b;
    logic [31:0] a;
    logic [2:0]  f;
    const logic [31:0] PWM = 32'hFFFF_FFFC;

    for (int unsigned i = 0; i < 4; i++) mduty[i] = '0;
    drive(1'b1, 1'b0, 3'd2, '0, '0, '0);
    step(); step();
    check32("rst_rdata", read_data, '0);
    check32("rst_fault", 32'(access_fault), '0);
    check32("rst_pwm", 32'({led, red, green, blue}), '0);

    tbl.push_back(mk(1, 3'd2, 32'h10, 32'h8899AABB, PWM, 32'h0, 0));
    tbl.push_back(mk(0, 3'd2, 0, 0, 32'h10, 32'h8899AABB, 0));
    tbl.push_back(mk(0, 3'd0, 0, 0, 32'h10, 32'hFFFFFFBB, 0));
    tbl.push_back(mk(0, 3'd4, 0, 0, 32'h13, 32'h00000088, 0));
    tbl.push_back(mk(0, 3'd1, 0, 0, 32'h12, 32'hFFFF8899, 0));
    tbl.push_back(mk(1, 3'd0, 32'h11, 32'h5A, PWM, 32'h0, 0));
    tbl.push_back(mk(0, 3'd2, 0, 0, 32'h10, 32'h88995ABB, 0));
    tbl.push_back(mk(1, 3'd1, 32'h12, 32'h1234, PWM, 32'h0, 0));
    tbl.push_back(mk(0, 3'd2, 0, 0, 32'h10, 32'h12345ABB, 0));
    tbl.push_back(mk(1, 3'd2, 32'h20, 32'hCAFEF00D, PWM, 32'h0, 0));
    tbl.push_back(mk(1, 3'd2, 32'h22, 32'hDEADBEEF, 32'h20, 32'hCAFEF00D, 1));
    tbl.push_back(mk(0, 3'd1, 0, 0, 32'h13, 32'h0, 1));
    tbl.push_back(mk(0, 3'd2, 0, 0, 32'h20, 32'hCAFEF00D, 0));
    tbl.push_back(mk(0, 3'd2, 0, 0, 32'h0001_0000, 32'h0, 1));
    tbl.push_back(mk(0, 3'd2, 0, 0, 32'h20, 32'hCAFEF00D, 0));
    tbl.push_back(mk(1, 3'd2, 32'h30, 32'h7, PWM, 32'h0, 0));
    tbl.push_back(mk(1, 3'd2, 32'h30, 32'h1, 32'h30, 32'h7, 0));
    tbl.push_back(mk(0, 3'd2, 0, 0, 32'h30, 32'h1, 0));
    tbl.push_back(mk(1, 3'd3, 32'h30, 32'hFF, 32'h30, 32'h0, 1));
    tbl.push_back(mk(0, 3'd2, 0, 0, 32'h30, 32'h1, 0));
    tbl.push_back(mk(1, 3'd2, 32'h1FFC, 32'h13579BDF, 32'h2000, 32'h0, 1));
    tbl.push_back(mk(0, 3'd2, 0, 0, 32'h1FFC, 32'h13579BDF, 0));
    tbl.push_back(mk(1, 3'd1, 32'hFFFF_FFFE, 32'hA5C3, PWM, 32'h0, 0));
    tbl.push_back(mk(0, 3'd2, 0, 0, PWM, 32'hA5C30000, 0));
    tbl.push_back(mk(1, 3'd0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'hFFFFFFA5, 0));
    tbl.push_back(mk(1, 3'd0, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFE, 32'hFFFFFFC3, 0));
    tbl.push_back(mk(0, 3'd2, 0, 0, PWM, 32'h0, 0));

    foreach (tbl[i]) begin
      drive(1'b0, tbl[i].we, tbl[i].f3, tbl[i].wa, tbl[i].wd, tbl[i].ra);
      step();
      check32($sformatf("vec%0d_rdata", i), read_data, tbl[i].rd);
      check32($sformatf("vec%0d_fault", i), 32'(access_fault), 32'(tbl[i].flt));
    end

    // Timers from a fresh reset
    apply(1'b1, 1'b0, 3'd2, '0, '0, 32'hFFFF_FFF8, "tmr_rst");
    drive(1'b0, 1'b0, 3'd2, '0, '0, 32'hFFFF_FFF8);
    for (int i = 0; i < 4100 && cyc < 4000; i++) step();
    check32("tmr_wait", cyc, 32'd4000);
    apply(1'b0, 1'b0, 3'd2, '0, '0, 32'hFFFF_FFF8, "tmr_micros");
    check32("tmr_micros_1000", read_data, 32'd1000);
    apply(1'b0, 1'b0, 3'd2, '0, '0, 32'hFFFF_FFF4, "tmr_millis");
    check32("tmr_millis_1", read_data, 32'd1);
    apply(1'b0, 1'b1, 3'd2, 32'hFFFF_FFF8, 32'd5, 32'hFFFF_FFF8, "tmr_wr");
    apply(1'b0, 1'b0, 3'd2, '0, '0, 32'hFFFF_FFF8, "tmr_after_wr");
    check32("tmr_micros_kept", read_data, 32'd1000);

    // Randomized traffic: preload two RAM windows so every read is modelled
    for (int unsigned w = 0; w < 64; w++) begin
      apply(1'b0, 1'b1, 3'd2, 32'(w * 4), $urandom, PWM, "pre_lo");
      apply(1'b0, 1'b1, 3'd2, 32'h1F00 + 32'(w * 4), $urandom, PWM, "pre_hi");
    end
    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 7))
        0, 1, 2, 3, 4: a = 32'($urandom_range(0, 255));
        5:             a = 32'h1F00 + 32'($urandom_range(0, 255));
        6:             a = 32'hFFFF_FFF4 + 32'($urandom_range(0, 11));
        default:       a = ($urandom_range(0, 1) == 0) ? 32'h2000 + 32'($urandom_range(0, 15))
                                                       : (32'h8000_0000 | $urandom);
      endcase
      if ($urandom_range(0, 15) == 0) f = 3'($urandom_range(0, 7));
      else case ($urandom_range(0, 4))
        0: f = 3'd0; 1: f = 3'd1; 2: f = 3'd2; 3: f = 3'd4; default: f = 3'd5;
      endcase
      apply(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), f,
            ($urandom_range(0, 1) == 0) ? a : 32'($urandom_range(0, 255)),
            $urandom, ($urandom_range(0, 1) == 0) ? a : 32'hFFFF_FFFC - 32'($urandom_range(0, 8)),
            "rnd");
    end

    // PWM duties: red 0xFF, green 0x80, blue 0, led 0
    apply(1'b0, 1'b1, 3'd2, PWM, 32'h00FF8000, PWM, "pwm_wr");
    drive(1'b0, 1'b0, 3'd2, '0, '0, PWM);
    hi_l = 0; hi_r = 0; hi_g = 0; hi_b = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      hi_l += int'(led); hi_r += int'(red); hi_g += int'(green); hi_b += int'(blue);
    end
    check32("pwm_red", 32'(hi_r), 32'd255);
    check32("pwm_green", 32'(hi_g), 32'd128);
    check32("pwm_blue", 32'(hi_b), 32'd0);
    check32("pwm_led", 32'(hi_l), 32'd0);
    for (int i = 0; i < 100; i++) step();
    drive(1'b1, 1'b1, 3'd2, 32'h40, 32'h1, PWM);
    step();
    check32("pwm_rst_outs", 32'({led, red, green, blue}), '0);
    check32("pwm_rst_rdata", read_data, '0);
    drive(1'b0, 1'b0, 3'd2, '0, '0, PWM);
    step();
    check32("pwm_rst_duty", read_data, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
